// File: rtl/rob_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rob_pkg
// Description : Shared types and default widths for the reorder-buffer
//               dependency tracker. The entry struct is sized by the ROB_*
//               constants; overriding the data or register-address width
//               parameters elsewhere requires editing these constants too.
// Contents    : ROB_DEPTH, ROB_ID_SIZE, ROB_REG_ADDRESS_SIZE,
//               ROB_REGISTER_SIZE, ROB_N_READ, rob_entry_t
// Revision    : 1.0 - initial release
// ============================================================================
package rob_pkg;

  localparam int ROB_DEPTH            = 8;
  localparam int ROB_ID_SIZE          = $clog2(ROB_DEPTH);
  localparam int ROB_REG_ADDRESS_SIZE = 5;
  localparam int ROB_REGISTER_SIZE    = 32;
  localparam int ROB_N_READ           = 2;

  typedef struct packed {
    logic                            valid;
    logic                            writes;
    logic [ROB_REG_ADDRESS_SIZE-1:0] addr;
    logic                            done;
    logic [ROB_REGISTER_SIZE-1:0]    value;
  } rob_entry_t;

endpackage
`default_nettype wire

// File: rtl/rob_dependency_tracker_if.sv
`default_nettype none
// ============================================================================
// Module      : rob_dependency_tracker_if
// Description : Bundles the flush, allocate, writeback, commit and lookup
//               signals of the reorder buffer.
// Modports    : master - decode/execute/regfile side (drives requests)
//               slave  - the reorder buffer itself
// Revision    : 1.0 - initial release
// ============================================================================
interface rob_dependency_tracker_if #(
  parameter int ID_SIZE          = rob_pkg::ROB_ID_SIZE,
  parameter int REG_ADDRESS_SIZE = rob_pkg::ROB_REG_ADDRESS_SIZE,
  parameter int REGISTER_SIZE    = rob_pkg::ROB_REGISTER_SIZE,
  parameter int N_READ           = rob_pkg::ROB_N_READ
);

  logic                                        flush;
  logic                                        alloc_valid;
  logic                                        alloc_writes;
  logic [REG_ADDRESS_SIZE-1:0]                 alloc_addr;
  logic                                        alloc_ready;
  logic [ID_SIZE-1:0]                          alloc_id;
  logic                                        wb_valid;
  logic [ID_SIZE-1:0]                          wb_id;
  logic [REGISTER_SIZE-1:0]                    wb_value;
  logic                                        commit_valid;
  logic                                        commit_ready;
  logic                                        commit_writes;
  logic [REG_ADDRESS_SIZE-1:0]                 commit_addr;
  logic [REGISTER_SIZE-1:0]                    commit_value;
  logic [N_READ-1:0][REG_ADDRESS_SIZE-1:0]     rd_addr;
  logic [N_READ-1:0]                           rd_dependency;
  logic [N_READ-1:0]                           rd_resolved;
  logic [N_READ-1:0][REGISTER_SIZE-1:0]        rd_value;

  modport master (
    output flush, alloc_valid, alloc_writes, alloc_addr,
    input  alloc_ready, alloc_id,
    output wb_valid, wb_id, wb_value,
    input  commit_valid, commit_writes, commit_addr, commit_value,
    output commit_ready,
    output rd_addr,
    input  rd_dependency, rd_resolved, rd_value
  );

  modport slave (
    input  flush, alloc_valid, alloc_writes, alloc_addr,
    output alloc_ready, alloc_id,
    input  wb_valid, wb_id, wb_value,
    output commit_valid, commit_writes, commit_addr, commit_value,
    input  commit_ready,
    input  rd_addr,
    output rd_dependency, rd_resolved, rd_value
  );

endinterface
`default_nettype wire

// File: rtl/rob_lookup.sv
`default_nettype none
// ============================================================================
// Module      : rob_lookup
// Description : Combinational youngest-producer selector for one source
//               register. Walks the ROB in age order starting at head; the
//               last matching entry seen is the youngest.
// Ports       : i_entries    - registered ROB entry array
//               i_head       - oldest entry ID
//               i_rd_addr    - source register to look up
//               o_dependency - a live producer exists
//               o_resolved   - that producer has completed
//               o_value      - producer value when resolved, else 0
// Revision    : 1.0 - initial release
// ============================================================================
module rob_lookup
  import rob_pkg::*;
#(
  parameter int DEPTH   = ROB_DEPTH,
  parameter int ID_SIZE = $clog2(DEPTH)
) (
  input  rob_entry_t                      i_entries [DEPTH],
  input  logic [ID_SIZE-1:0]              i_head,
  input  logic [ROB_REG_ADDRESS_SIZE-1:0] i_rd_addr,
  output logic                            o_dependency,
  output logic                            o_resolved,
  output logic [ROB_REGISTER_SIZE-1:0]    o_value
);

  logic               w_found;
  logic [ID_SIZE-1:0] w_sel;
  logic [ID_SIZE-1:0] w_idx;
  rob_entry_t         w_sel_entry;

  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = '0;
    // Offset k is the age rank relative to head, so the raw ID never
    // decides ordering and wrap-around is handled naturally.
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = i_head + ID_SIZE'(k);
      if (i_entries[w_idx].valid && i_entries[w_idx].writes &&
          (i_entries[w_idx].addr == i_rd_addr) && (i_rd_addr != '0)) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
    w_sel_entry  = i_entries[w_sel];
    o_dependency = w_found;
    o_resolved   = w_found && w_sel_entry.done;
    o_value      = o_resolved ? w_sel_entry.value : '0;
  end

endmodule
`default_nettype wire

// File: rtl/rob_dependency_tracker.sv
`default_nettype none
// ============================================================================
// Module      : rob_dependency_tracker
// Description : Circular reorder buffer owning in-flight destination state.
//               Allocates at tail, completes by ID, commits in order at head,
//               and answers N_READ source-register dependency lookups from
//               registered state.
// Ports       : clk   - clock, rising edge
//               reset - synchronous, active-high
//               bus   - slave side of rob_dependency_tracker_if
//                       (flush, alloc_*, wb_*, commit_*, rd_*)
// Revision    : 1.0 - initial release
// ============================================================================
module rob_dependency_tracker
  import rob_pkg::*;
#(
  parameter int DEPTH            = ROB_DEPTH,
  parameter int ID_SIZE          = $clog2(DEPTH),
  parameter int REG_ADDRESS_SIZE = ROB_REG_ADDRESS_SIZE,
  parameter int REGISTER_SIZE    = ROB_REGISTER_SIZE,
  parameter int N_READ           = ROB_N_READ
) (
  input  logic                    clk,
  input  logic                    reset,
  rob_dependency_tracker_if.slave bus
);

  localparam logic [ID_SIZE:0] C_FULL_COUNT = (ID_SIZE + 1)'(DEPTH);

  rob_entry_t         entries_q [DEPTH];
  rob_entry_t         entries_d [DEPTH];
  logic [ID_SIZE-1:0] head_q, head_d;
  logic [ID_SIZE-1:0] tail_q, tail_d;
  logic [ID_SIZE:0]   count_q, count_d;

  rob_entry_t         w_head_entry;
  logic               w_not_full;
  logic               w_commit_valid;
  logic               w_fire_alloc;
  logic               w_fire_commit;

  logic                           w_rd_dep [N_READ];
  logic                           w_rd_res [N_READ];
  logic [REGISTER_SIZE-1:0]       w_rd_val [N_READ];

  // Handshake decode, all from registered state. Fullness deliberately
  // ignores a same-cycle commit so alloc_ready has no combinational path
  // from commit_ready.
  always_comb begin
    w_head_entry   = entries_q[head_q];
    w_not_full     = (count_q != C_FULL_COUNT);
    w_commit_valid = w_head_entry.valid && w_head_entry.done;
    w_fire_alloc   = bus.alloc_valid && w_not_full;
    w_fire_commit  = w_commit_valid && bus.commit_ready;
  end

  assign bus.alloc_ready   = w_not_full;
  assign bus.alloc_id      = tail_q;
  assign bus.commit_valid  = w_commit_valid;
  assign bus.commit_writes = w_commit_valid && w_head_entry.writes;
  assign bus.commit_addr   = w_commit_valid ? w_head_entry.addr  : '0;
  assign bus.commit_value  = w_commit_valid ? w_head_entry.value : '0;

  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;

    if (bus.flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_d[i].valid = 1'b0;
      end
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // Only the first writeback to a live entry lands.
      if (bus.wb_valid && entries_q[bus.wb_id].valid &&
          !entries_q[bus.wb_id].done) begin
        entries_d[bus.wb_id].done  = 1'b1;
        entries_d[bus.wb_id].value = bus.wb_value;
      end

      if (w_fire_commit) begin
        entries_d[head_q].valid = 1'b0;
        head_d                  = head_q + ID_SIZE'(1);
      end

      // Tail is never valid when an allocation fires, so this cannot
      // collide with the writeback or commit updates above.
      if (w_fire_alloc) begin
        entries_d[tail_q] = '{valid:  1'b1,
                              writes: bus.alloc_writes,
                              addr:   bus.alloc_addr,
                              done:   1'b0,
                              value:  '0};
        tail_d            = tail_q + ID_SIZE'(1);
      end

      case ({w_fire_alloc, w_fire_commit})
        2'b10:   count_d = count_q + (ID_SIZE + 1)'(1);
        2'b01:   count_d = count_q - (ID_SIZE + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      entries_q <= entries_d;
    end
  end

  generate
    for (genvar p = 0; p < N_READ; p++) begin : g_lookup
      rob_lookup #(
        .DEPTH   (DEPTH),
        .ID_SIZE (ID_SIZE)
      ) u_lookup (
        .i_entries    (entries_q),
        .i_head       (head_q),
        .i_rd_addr    (bus.rd_addr[p]),
        .o_dependency (w_rd_dep[p]),
        .o_resolved   (w_rd_res[p]),
        .o_value      (w_rd_val[p])
      );
    end
  endgenerate

  always_comb begin
    for (int p = 0; p < N_READ; p++) begin
      bus.rd_dependency[p] = w_rd_dep[p];
      bus.rd_resolved[p]   = w_rd_res[p];
      bus.rd_value[p]      = w_rd_val[p];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rob_dependency_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_rob_dependency_tracker
// Description : Self-checking bench for rob_dependency_tracker. Each vector
//               drives one cycle of inputs, checks the outputs that result
//               from the state before that cycle's edge, then clocks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rob_dependency_tracker;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  rob_dependency_tracker_if #(
    .ID_SIZE(3), .REG_ADDRESS_SIZE(5), .REGISTER_SIZE(32), .N_READ(2)
  ) bus_if ();

  rob_dependency_tracker #(
    .DEPTH(8), .ID_SIZE(3), .REG_ADDRESS_SIZE(5), .REGISTER_SIZE(32), .N_READ(2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        flush;
    logic        alloc_valid;
    logic        alloc_writes;
    logic [4:0]  alloc_addr;
    logic        wb_valid;
    logic [2:0]  wb_id;
    logic [31:0] wb_value;
    logic        commit_ready;
    logic [4:0]  rd0;
    logic [4:0]  rd1;
    logic        e_ready;
    logic [2:0]  e_id;
    logic        e_cv;
    logic        e_cw;
    logic [4:0]  e_caddr;
    logic [31:0] e_cval;
    logic        e_dep0;
    logic        e_res0;
    logic [31:0] e_val0;
    logic        e_dep1;
    logic        e_res1;
    logic [31:0] e_val1;
  } vec_t;

  // Argument order: inputs (flush, alloc v/w/addr, wb v/id/value,
  // commit_ready, rd0, rd1) then expected (ready, id, commit v/w/addr/value,
  // port0 dep/res/val, port1 dep/res/val).
  function automatic vec_t mk(
    input int fl, input int av, input int aw, input int aa,
    input int wv, input int wi, input logic [31:0] wval, input int cr,
    input int r0, input int r1,
    input int er, input int eid, input int ecv, input int ecw, input int eca,
    input logic [31:0] ecval,
    input int d0, input int s0, input logic [31:0] v0,
    input int d1, input int s1, input logic [31:0] v1);
    vec_t v;
    v.flush        = fl[0];
    v.alloc_valid  = av[0];
    v.alloc_writes = aw[0];
    v.alloc_addr   = aa[4:0];
    v.wb_valid     = wv[0];
    v.wb_id        = wi[2:0];
    v.wb_value     = wval;
    v.commit_ready = cr[0];
    v.rd0          = r0[4:0];
    v.rd1          = r1[4:0];
    v.e_ready      = er[0];
    v.e_id         = eid[2:0];
    v.e_cv         = ecv[0];
    v.e_cw         = ecw[0];
    v.e_caddr      = eca[4:0];
    v.e_cval       = ecval;
    v.e_dep0       = d0[0];
    v.e_res0       = s0[0];
    v.e_val0       = v0;
    v.e_dep1       = d1[0];
    v.e_res1       = s1[0];
    v.e_val1       = v1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus_if.flush        = v.flush;
    bus_if.alloc_valid  = v.alloc_valid;
    bus_if.alloc_writes = v.alloc_writes;
    bus_if.alloc_addr   = v.alloc_addr;
    bus_if.wb_valid     = v.wb_valid;
    bus_if.wb_id        = v.wb_id;
    bus_if.wb_value     = v.wb_value;
    bus_if.commit_ready = v.commit_ready;
    bus_if.rd_addr[0]   = v.rd0;
    bus_if.rd_addr[1]   = v.rd1;
  endtask

  // Called at a falling edge; checks half a cycle away from the rising edge.
  task automatic apply(input vec_t v, input string tag);
    drive(v);
    #1;
    chk({tag, ".alloc_ready"},   32'(bus_if.alloc_ready),      32'(v.e_ready));
    chk({tag, ".alloc_id"},      32'(bus_if.alloc_id),         32'(v.e_id));
    chk({tag, ".commit_valid"},  32'(bus_if.commit_valid),     32'(v.e_cv));
    chk({tag, ".commit_writes"}, 32'(bus_if.commit_writes),    32'(v.e_cw));
    chk({tag, ".commit_addr"},   32'(bus_if.commit_addr),      32'(v.e_caddr));
    chk({tag, ".commit_value"},  bus_if.commit_value,          v.e_cval);
    chk({tag, ".rd_dep0"},       32'(bus_if.rd_dependency[0]), 32'(v.e_dep0));
    chk({tag, ".rd_res0"},       32'(bus_if.rd_resolved[0]),   32'(v.e_res0));
    chk({tag, ".rd_val0"},       bus_if.rd_value[0],           v.e_val0);
    chk({tag, ".rd_dep1"},       32'(bus_if.rd_dependency[1]), 32'(v.e_dep1));
    chk({tag, ".rd_res1"},       32'(bus_if.rd_resolved[1]),   32'(v.e_res1));
    chk({tag, ".rd_val1"},       bus_if.rd_value[1],           v.e_val1);
    @(negedge clk);
  endtask

  vec_t tbl [21];

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // Basic dependency, writeback latency, repeated writeback, r0,
    // non-writing entries, two-port lookups, in-order commit, plain flush.
    tbl[0]  = mk(0,0,0,0, 0,0,0,       0, 5,0, 1,0, 0,0,0,0,       0,0,0,       0,0,0);
    tbl[1]  = mk(0,1,1,5, 0,0,0,       0, 5,0, 1,0, 0,0,0,0,       0,0,0,       0,0,0);
    tbl[2]  = mk(0,1,1,5, 0,0,0,       0, 5,0, 1,1, 0,0,0,0,       1,0,0,       0,0,0);
    tbl[3]  = mk(0,0,0,0, 0,0,0,       0, 5,0, 1,2, 0,0,0,0,       1,0,0,       0,0,0);
    tbl[4]  = mk(0,0,0,0, 1,1,'hBEEF,  0, 5,0, 1,2, 0,0,0,0,       1,0,0,       0,0,0);
    tbl[5]  = mk(0,0,0,0, 1,0,'h1234,  0, 5,0, 1,2, 0,0,0,0,       1,1,'hBEEF,  0,0,0);
    tbl[6]  = mk(0,0,0,0, 0,0,0,       0, 5,0, 1,2, 1,1,5,'h1234,  1,1,'hBEEF,  0,0,0);
    tbl[7]  = mk(0,0,0,0, 1,1,'hDEAD,  0, 5,0, 1,2, 1,1,5,'h1234,  1,1,'hBEEF,  0,0,0);
    tbl[8]  = mk(0,1,1,0, 0,0,0,       0, 5,0, 1,2, 1,1,5,'h1234,  1,1,'hBEEF,  0,0,0);
    tbl[9]  = mk(0,1,1,2, 0,0,0,       0, 0,2, 1,3, 1,1,5,'h1234,  0,0,0,       0,0,0);
    tbl[10] = mk(0,1,1,9, 0,0,0,       0, 2,9, 1,4, 1,1,5,'h1234,  1,0,0,       0,0,0);
    tbl[11] = mk(0,0,0,0, 1,3,'h2222,  0, 2,9, 1,5, 1,1,5,'h1234,  1,0,0,       1,0,0);
    tbl[12] = mk(0,0,0,0, 0,0,0,       0, 2,9, 1,5, 1,1,5,'h1234,  1,1,'h2222,  1,0,0);
    tbl[13] = mk(0,1,0,9, 0,0,0,       0, 2,9, 1,5, 1,1,5,'h1234,  1,1,'h2222,  1,0,0);
    tbl[14] = mk(0,0,0,0, 1,5,'h5555,  0, 2,9, 1,6, 1,1,5,'h1234,  1,1,'h2222,  1,0,0);
    tbl[15] = mk(0,0,0,0, 0,0,0,       0, 2,9, 1,6, 1,1,5,'h1234,  1,1,'h2222,  1,0,0);
    tbl[16] = mk(0,0,0,0, 0,0,0,       1, 5,9, 1,6, 1,1,5,'h1234,  1,1,'hBEEF,  1,0,0);
    tbl[17] = mk(0,0,0,0, 0,0,0,       1, 5,9, 1,6, 1,1,5,'hBEEF,  1,1,'hBEEF,  1,0,0);
    tbl[18] = mk(0,0,0,0, 0,0,0,       1, 5,9, 1,6, 0,0,0,0,       0,0,0,       1,0,0);
    tbl[19] = mk(1,0,0,0, 0,0,0,       0, 2,9, 1,6, 0,0,0,0,       1,1,'h2222,  1,0,0);
    tbl[20] = mk(0,0,0,0, 0,0,0,       0, 2,9, 1,0, 0,0,0,0,       0,0,0,       0,0,0);

    reset = 1'b1;
    drive(mk(0,0,0,0, 0,0,0,0, 0,0, 0,0,0,0,0,0, 0,0,0, 0,0,0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 21; i++) begin
      apply(tbl[i], $sformatf("A%0d", i));
    end

    // Fill to full, then a refused alloc alongside a commit; tail wraps to 0.
    for (int i = 0; i < 8; i++) begin
      apply(mk(0,1,1,10+i, 0,0,0,0, 0,0, 1,i, 0,0,0,0, 0,0,0, 0,0,0),
            $sformatf("fill%0d", i));
    end
    apply(mk(0,0,0,0, 1,0,'hA0,0, 0,0, 0,0, 0,0,0,0, 0,0,0, 0,0,0), "full_wb");
    apply(mk(0,1,1,20, 0,0,0,1, 10,0, 0,0, 1,1,10,'hA0, 1,1,'hA0, 0,0,0), "full_alloc_commit");
    apply(mk(0,0,0,0, 0,0,0,0, 10,20, 1,0, 0,0,0,0, 0,0,0, 0,0,0), "after_full");

    // Move head to 6 with non-writing entries.
    apply(mk(1,0,0,0, 0,0,0,0, 0,0, 1,0, 0,0,0,0, 0,0,0, 0,0,0), "flush_mid");
    for (int i = 0; i < 6; i++) begin
      apply(mk(0,1,0,0, 0,0,0,0, 0,0, 1,i, 0,0,0,0, 0,0,0, 0,0,0),
            $sformatf("pad%0d", i));
    end
    for (int k = 0; k < 7; k++) begin
      apply(mk(0,0,0,0, (k < 6) ? 1 : 0, k, 0, 1, 0,0,
               1,6, (k >= 1) ? 1 : 0, 0,0,0, 0,0,0, 0,0,0),
            $sformatf("drain%0d", k));
    end

    // Wrap ordering: id6 and id1 both write r3; id1 is youngest.
    apply(mk(0,1,1,3, 0,0,0,0, 3,0, 1,6, 0,0,0,0,      0,0,0,      0,0,0),      "W0");
    apply(mk(0,1,1,7, 0,0,0,0, 3,0, 1,7, 0,0,0,0,      1,0,0,      0,0,0),      "W1");
    apply(mk(0,1,1,5, 0,0,0,0, 3,0, 1,0, 0,0,0,0,      1,0,0,      0,0,0),      "W2");
    apply(mk(0,1,1,3, 0,0,0,0, 3,0, 1,1, 0,0,0,0,      1,0,0,      0,0,0),      "W3");
    apply(mk(0,0,0,0, 1,6,'h11,0, 3,0, 1,2, 0,0,0,0,   1,0,0,      0,0,0),      "W4");
    apply(mk(0,0,0,0, 1,7,'h55,0, 3,0, 1,2, 1,1,3,'h11, 1,0,0,     0,0,0),      "W5");
    apply(mk(0,0,0,0, 1,1,'h22,0, 3,7, 1,2, 1,1,3,'h11, 1,0,0,     1,1,'h55),   "W6");
    apply(mk(0,0,0,0, 0,0,0,1, 3,7, 1,2, 1,1,3,'h11,   1,1,'h22,   1,1,'h55),   "W7");

    // Commit backpressure on r7 = 0x55.
    for (int i = 0; i < 3; i++) begin
      apply(mk(0,0,0,0, 0,0,0,0, 3,7, 1,2, 1,1,7,'h55, 1,1,'h22, 1,1,'h55),
            $sformatf("hold%0d", i));
    end
    apply(mk(0,0,0,0, 0,0,0,1, 3,7, 1,2, 1,1,7,'h55, 1,1,'h22, 1,1,'h55), "B_commit");
    apply(mk(0,0,0,0, 0,0,0,0, 3,7, 1,2, 0,0,0,0,    1,1,'h22, 0,0,0),    "B_after");

    // Flush colliding with alloc, writeback and a firing commit.
    apply(mk(0,1,1,6, 1,0,'h99,0, 5,6, 1,2, 0,0,0,0,    1,0,0,      0,0,0), "F1");
    apply(mk(1,1,1,8, 1,2,'h77,1, 5,6, 1,3, 1,1,5,'h99, 1,1,'h99,   1,0,0), "F2");
    apply(mk(0,0,0,0, 0,0,0,0, 5,8, 1,0, 0,0,0,0,       0,0,0,      0,0,0), "F3");
    apply(mk(0,1,1,8, 0,0,0,0, 3,6, 1,0, 0,0,0,0,       0,0,0,      0,0,0), "F4");
    apply(mk(0,0,0,0, 0,0,0,0, 8,0, 1,1, 0,0,0,0,       1,0,0,      0,0,0), "F5");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
